// File: rtl/pong_pkg.sv
// Shared types and helpers for the pong match controller: state encoding,
// player-index width and saturating multi-digit BCD arithmetic.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_e;

    localparam int MAX_DIGITS = 4;

    function automatic int player_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Adds one to the low 'digits' BCD digits; an all-nines value is held.
    function automatic logic [4*MAX_DIGITS-1:0] bcd_inc(input logic [4*MAX_DIGITS-1:0] v,
                                                        input int digits);
        logic [4*MAX_DIGITS-1:0] r;
        logic carry;
        logic all_nines;
        r         = v;
        carry     = 1'b1;
        all_nines = 1'b1;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if (k < digits) begin
                if (v[4*k +: 4] != 4'd9) all_nines = 1'b0;
                if (carry) begin
                    if (v[4*k +: 4] == 4'd9) begin
                        r[4*k +: 4] = 4'd0;
                    end else begin
                        r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        if (all_nines) r = v;
        return r;
    endfunction

    function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int value);
        logic [4*MAX_DIGITS-1:0] r;
        int rem;
        r   = '0;
        rem = value;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            r[4*k +: 4] = 4'(rem % 10);
            rem         = rem / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/pong_bcd_score.sv
// One player's saturating BCD score counter with clear, increment and a
// compare against the binary winning score (0 disables the compare).
module pong_bcd_score
    import pong_pkg::*;
#(
    parameter int SCORE_DIGITS = 1,
    parameter int WIN_SCORE    = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr_i,
    input  logic                      inc_i,
    output logic [4*SCORE_DIGITS-1:0] score_o,
    output logic                      win_o
);

    localparam logic [4*MAX_DIGITS-1:0] WIN_BCD = to_bcd(WIN_SCORE);

    logic [4*MAX_DIGITS-1:0] score_q, score_d;

    always_comb begin
        score_d = score_q;
        if (clr_i) begin
            score_d = '0;
        end else if (inc_i) begin
            score_d = bcd_inc(score_q, SCORE_DIGITS);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) score_q <= '0;
        else       score_q <= score_d;
    end

    assign score_o = score_q[4*SCORE_DIGITS-1:0];
    assign win_o   = (WIN_SCORE != 0) && (score_q == WIN_BCD);

endmodule

// File: rtl/pong_match.sv
// Match controller: serve / rally / point / game-over sequencing with BCD scores.
// Optional rally speed-up is built only when PONG_SPEEDUP_EN is defined.
module pong_match
    import pong_pkg::*;
#(
    parameter int  NUM_PLAYERS    = 2,
    parameter int  SCORE_DIGITS   = 1,
    parameter int  WIN_SCORE      = 9,
    parameter int  SERVE_FRAMES   = 60,
    parameter int  HITS_PER_LEVEL = 4,
    parameter int  MAX_LEVEL      = 3,
    localparam int PW             = player_w(NUM_PLAYERS),
    localparam int LW             = $clog2(MAX_LEVEL + 1),
    localparam int SW             = NUM_PLAYERS * 4 * SCORE_DIGITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   frame_tick,
    input  logic [NUM_PLAYERS-1:0] hit,
    input  logic [NUM_PLAYERS-1:0] miss,
    output logic [2:0]             state,
    output logic                   ball_run,
    output logic [PW-1:0]          serve_to,
    output logic [SW-1:0]          score,
    output logic                   point_pulse,
    output logic [PW-1:0]          winner,
    output logic                   winner_valid,
    output logic [LW-1:0]          speed_level
);

    localparam int FW = (SERVE_FRAMES > 0) ? $clog2(SERVE_FRAMES + 1) : 1;

    state_e           state_q, state_d;
    logic             start_q;
    logic [FW-1:0]    frame_cnt_q, frame_cnt_d;
    logic [PW-1:0]    serve_to_q, serve_to_d;
    logic [PW-1:0]    last_hit_q, last_hit_d;
    logic             last_valid_q, last_valid_d;
    logic [PW-1:0]    credit_q, credit_d;
    logic             credited_q, credited_d;
    logic [PW-1:0]    winner_q, winner_d;
    logic             ball_run_q, point_pulse_q, winner_valid_q;

    logic                   start_rise, miss_any, hit_any, hit_accept;
    logic [PW-1:0]          miss_idx, hit_idx;
    logic                   credit_en, serve_entry, clr_scores, win_sel;
    logic [NUM_PLAYERS-1:0] win_vec;

    assign start_rise = start && !start_q;
    assign miss_any   = |miss;
    assign hit_any    = |hit;
    assign hit_accept = (state_q == PLAY) && hit_any && !miss_any;

    // Lowest-numbered set bit wins when several goals/paddles fire together.
    always_comb begin
        miss_idx = '0;
        hit_idx  = '0;
        win_sel  = 1'b0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (miss[i]) miss_idx = PW'(i);
            if (hit[i])  hit_idx  = PW'(i);
        end
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (win_vec[i] && (credit_q == PW'(i))) win_sel = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        serve_to_d   = serve_to_q;
        last_hit_d   = last_hit_q;
        last_valid_d = last_valid_q;
        credit_d     = credit_q;
        credited_d   = credited_q;
        winner_d     = winner_q;
        credit_en    = 1'b0;
        case (state_q)
            IDLE: if (start_rise) state_d = SERVE;
            SERVE: begin
                if (frame_cnt_q == FW'(SERVE_FRAMES)) state_d = PLAY;
                else if (frame_tick) frame_cnt_d = frame_cnt_q + 1'b1;
            end
            PLAY: begin
                if (miss_any) begin
                    state_d    = POINT;
                    serve_to_d = miss_idx;
                    credit_d   = last_hit_q;
                    credited_d = last_valid_q && (last_hit_q != miss_idx);
                    credit_en  = credited_d;
                end else if (hit_any) begin
                    last_hit_d   = hit_idx;
                    last_valid_d = 1'b1;
                end
            end
            POINT: begin
                if (credited_q && win_sel) begin
                    state_d  = OVER;
                    winner_d = credit_q;
                end else begin
                    state_d = SERVE;
                end
            end
            OVER: if (start_rise) state_d = SERVE;
            default: state_d = IDLE;
        endcase
        serve_entry = (state_d == SERVE) && (state_q != SERVE);
        clr_scores  = serve_entry && ((state_q == IDLE) || (state_q == OVER));
        if (serve_entry) frame_cnt_d = '0;
        if (clr_scores) begin
            serve_to_d   = '0;
            last_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            start_q        <= 1'b1;
            frame_cnt_q    <= '0;
            serve_to_q     <= '0;
            last_hit_q     <= '0;
            last_valid_q   <= 1'b0;
            credit_q       <= '0;
            credited_q     <= 1'b0;
            winner_q       <= '0;
            ball_run_q     <= 1'b0;
            point_pulse_q  <= 1'b0;
            winner_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start;
            frame_cnt_q    <= frame_cnt_d;
            serve_to_q     <= serve_to_d;
            last_hit_q     <= last_hit_d;
            last_valid_q   <= last_valid_d;
            credit_q       <= credit_d;
            credited_q     <= credited_d;
            winner_q       <= winner_d;
            ball_run_q     <= (state_d == PLAY);
            point_pulse_q  <= (state_d == POINT);
            winner_valid_q <= (state_d == OVER);
        end
    end

    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
        pong_bcd_score #(
            .SCORE_DIGITS(SCORE_DIGITS),
            .WIN_SCORE   (WIN_SCORE)
        ) u_score (
            .clk    (clk),
            .reset  (reset),
            .clr_i  (clr_scores),
            .inc_i  (credit_en && (last_hit_q == PW'(gi))),
            .score_o(score[gi*4*SCORE_DIGITS +: 4*SCORE_DIGITS]),
            .win_o  (win_vec[gi])
        );
    end

`ifdef PONG_SPEEDUP_EN
    localparam int HW = $clog2(HITS_PER_LEVEL + 1);

    logic [HW-1:0] rally_hits_q, rally_hits_d;
    logic [LW-1:0] level_q, level_d;

    always_comb begin
        rally_hits_d = rally_hits_q;
        level_d      = level_q;
        if (serve_entry) begin
            rally_hits_d = '0;
            level_d      = '0;
        end else if (hit_accept) begin
            if (rally_hits_q == HW'(HITS_PER_LEVEL - 1)) begin
                rally_hits_d = '0;
                if (level_q != LW'(MAX_LEVEL)) level_d = level_q + 1'b1;
            end else begin
                rally_hits_d = rally_hits_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rally_hits_q <= '0;
            level_q      <= '0;
        end else begin
            rally_hits_q <= rally_hits_d;
            level_q      <= level_d;
        end
    end

    assign speed_level = level_q;
`else
    logic unused_speed;
    assign unused_speed = hit_accept;
    assign speed_level  = '0;
`endif

    assign state        = state_q;
    assign ball_run     = ball_run_q;
    assign serve_to     = serve_to_q;
    assign point_pulse  = point_pulse_q;
    assign winner       = winner_q;
    assign winner_valid = winner_valid_q;

endmodule

// File: tb/tb_pong_match.sv
// Directed bench for pong_match: two instances (2-player win-at-3 and a
// 4-player endless single-digit match) with a scoreboard of expected points.
module tb_pong_match;
    import pong_pkg::*;

    typedef struct {
        logic [15:0] score;
        logic [1:0]  serve_to;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       a_start = 1'b1, a_tick = 1'b0;
    logic [1:0] a_hit = '0, a_miss = '0;
    logic [2:0] a_state;
    logic       a_ball_run, a_serve_to, a_point_pulse, a_winner, a_winner_valid;
    logic [7:0] a_score;
    logic [1:0] a_speed;

    logic        b_start = 1'b1, b_tick = 1'b0;
    logic [3:0]  b_hit = '0, b_miss = '0;
    logic [2:0]  b_state;
    logic        b_ball_run, b_point_pulse, b_winner_valid;
    logic [1:0]  b_serve_to, b_winner, b_speed;
    logic [15:0] b_score;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    pong_match #(.NUM_PLAYERS(2), .SCORE_DIGITS(1), .WIN_SCORE(3), .SERVE_FRAMES(60)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .frame_tick(a_tick),
        .hit(a_hit), .miss(a_miss), .state(a_state), .ball_run(a_ball_run),
        .serve_to(a_serve_to), .score(a_score), .point_pulse(a_point_pulse),
        .winner(a_winner), .winner_valid(a_winner_valid), .speed_level(a_speed)
    );

    pong_match #(.NUM_PLAYERS(4), .SCORE_DIGITS(1), .WIN_SCORE(0), .SERVE_FRAMES(0)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .frame_tick(b_tick),
        .hit(b_hit), .miss(b_miss), .state(b_state), .ball_run(b_ball_run),
        .serve_to(b_serve_to), .score(b_score), .point_pulse(b_point_pulse),
        .winner(b_winner), .winner_valid(b_winner_valid), .speed_level(b_speed)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_a(input int st, input string tag);
        for (int k = 0; k < 8 && 32'(a_state) != st; k++) cyc(1);
        chk(tag, 32'(a_state), st);
    endtask

    task automatic wait_b(input int st, input string tag);
        for (int k = 0; k < 8 && 32'(b_state) != st; k++) cyc(1);
        chk(tag, 32'(b_state), st);
    endtask

    task automatic serve_a();
        wait_a(32'(SERVE), "a_serve_enter");
        for (int k = 0; k < 60; k++) begin
            a_tick = 1'b1; cyc(1);
            a_tick = 1'b0; cyc(1);
        end
        wait_a(32'(PLAY), "a_play_enter");
    endtask

    task automatic hit_a(input logic [1:0] h);
        a_hit = h; cyc(1); a_hit = '0;
    endtask

    task automatic hit_b(input logic [3:0] h);
        b_hit = h; cyc(1); b_hit = '0;
    endtask

    task automatic point_a(input logic [1:0] h, input logic [1:0] m,
                           input logic [15:0] esc, input logic [1:0] est);
        exp_t e;
        qa.push_back('{esc, est});
        a_hit = h; a_miss = m; cyc(1);
        a_hit = '0; a_miss = '0;
        for (int k = 0; k < 4 && !a_point_pulse; k++) cyc(1);
        chk("a_pulse", 32'(a_point_pulse), 1);
        e = qa.pop_front();
        chk("a_score", 32'(a_score), 32'(e.score));
        chk("a_serve_to", 32'(a_serve_to), 32'(e.serve_to));
        chk("a_state_point", 32'(a_state), 32'(POINT));
        cyc(1);
        chk("a_pulse_len", 32'(a_point_pulse), 0);
    endtask

    task automatic point_b(input logic [3:0] h, input logic [3:0] m,
                           input logic [15:0] esc, input logic [1:0] est);
        exp_t e;
        qb.push_back('{esc, est});
        b_hit = h; b_miss = m; cyc(1);
        b_hit = '0; b_miss = '0;
        for (int k = 0; k < 4 && !b_point_pulse; k++) cyc(1);
        chk("b_pulse", 32'(b_point_pulse), 1);
        e = qb.pop_front();
        chk("b_score", 32'(b_score), 32'(e.score));
        chk("b_serve_to", 32'(b_serve_to), 32'(e.serve_to));
        cyc(1);
        chk("b_pulse_len", 32'(b_point_pulse), 0);
    endtask

    initial begin
        // Reset with start held high: no game may begin afterwards.
        cyc(2);
        reset = 1'b0;
        cyc(1);
        chk("rst_state", 32'(a_state), 32'(IDLE));
        chk("rst_ball_run", 32'(a_ball_run), 0);
        chk("rst_serve_to", 32'(a_serve_to), 0);
        chk("rst_score", 32'(a_score), 0);
        chk("rst_pulse", 32'(a_point_pulse), 0);
        chk("rst_winner", 32'(a_winner), 0);
        chk("rst_winner_valid", 32'(a_winner_valid), 0);
        chk("rst_speed", 32'(a_speed), 0);
        cyc(3);
        chk("a_held_start", 32'(a_state), 32'(IDLE));

        // Match start, SERVE frame count boundary.
        a_start = 1'b0; cyc(1);
        a_start = 1'b1; cyc(1);
        chk("a_start_serve", 32'(a_state), 32'(SERVE));
        chk("a_serve_ball", 32'(a_ball_run), 0);
        for (int k = 0; k < 59; k++) begin
            a_tick = 1'b1; cyc(1);
            a_tick = 1'b0; cyc(1);
        end
        chk("a_serve_59", 32'(a_state), 32'(SERVE));
        a_tick = 1'b1; cyc(1);
        a_tick = 1'b0; cyc(1);
        chk("a_play_60", 32'(a_state), 32'(PLAY));
        chk("a_play_ball", 32'(a_ball_run), 1);

        // Player 1 hits, ball passes goal 0.
        hit_a(2'b10);
        point_a(2'b00, 2'b01, 16'h0010, 2'd0);
        chk("a_back_serve", 32'(a_state), 32'(SERVE));

        // Own goal, then hit and miss in the same cycle.
        serve_a();
        point_a(2'b00, 2'b10, 16'h0010, 2'd1);
        serve_a();
        point_a(2'b01, 2'b10, 16'h0010, 2'd1);

        // Player 0 reaches WIN_SCORE = 3.
        for (int p = 1; p <= 3; p++) begin
            serve_a();
            hit_a(2'b01);
            point_a(2'b00, 2'b10, 16'(16'h0010 + p), 2'd1);
        end
        chk("a_over", 32'(a_state), 32'(OVER));
        chk("a_winner_valid", 32'(a_winner_valid), 1);
        chk("a_winner", 32'(a_winner), 0);
        chk("a_over_ball", 32'(a_ball_run), 0);
        cyc(2);
        chk("a_over_hold_score", 32'(a_score), 32'h13);
        a_start = 1'b0; cyc(1);
        a_start = 1'b1; cyc(1);
        chk("a_restart_state", 32'(a_state), 32'(SERVE));
        chk("a_restart_score", 32'(a_score), 0);
        chk("a_restart_wv", 32'(a_winner_valid), 0);

        // Endless 4-player match: one-cycle SERVE, BCD saturation.
        b_start = 1'b0; cyc(1);
        b_start = 1'b1; cyc(1);
        chk("b_serve", 32'(b_state), 32'(SERVE));
        cyc(1);
        chk("b_serve_one_cycle", 32'(b_state), 32'(PLAY));
        for (int p = 1; p <= 11; p++) begin
            hit_b(4'b0010);
            point_b(4'b0000, 4'b0001, 16'(((p > 9) ? 9 : p) << 4), 2'd0);
            wait_b(32'(PLAY), "b_replay");
        end

        // Long rally: speed level saturates (fixed at 0 without the speed-up).
        for (int k = 0; k < 13; k++) hit_b(4'b0100);
`ifdef PONG_SPEEDUP_EN
        chk("b_speed_13", 32'(b_speed), 3);
`else
        chk("b_speed_13", 32'(b_speed), 0);
`endif
        point_b(4'b0000, 4'b0001, 16'h0190, 2'd0);
        chk("b_speed_serve", 32'(b_speed), 0);
        wait_b(32'(PLAY), "b_replay2");

        // Two goals at once: lowest index (goal 1) is taken.
        hit_b(4'b1000);
        point_b(4'b0000, 4'b0110, 16'h1190, 2'd1);
        chk("b_winner_valid", 32'(b_winner_valid), 0);

        // Reset in the middle of a rally with nonzero scores.
        serve_a();
        hit_a(2'b01);
        point_a(2'b00, 2'b10, 16'h0001, 2'd1);
        serve_a();
        reset = 1'b1; cyc(1);
        reset = 1'b0;
        chk("mid_rst_state", 32'(a_state), 32'(IDLE));
        chk("mid_rst_score", 32'(a_score), 0);
        chk("mid_rst_ball", 32'(a_ball_run), 0);
        chk("mid_rst_serve_to", 32'(a_serve_to), 0);
        chk("mid_rst_b_score", 32'(b_score), 0);
        chk("mid_rst_b_serve_to", 32'(b_serve_to), 0);
        cyc(3);
        chk("mid_rst_held_a", 32'(a_state), 32'(IDLE));
        chk("mid_rst_held_b", 32'(b_state), 32'(IDLE));
        chk("sb_empty", 32'(qa.size() + qb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_match.md
# pong_match

Parametrised match controller for the pong design. It generalises the fixed two-player, 4-bit-score game to NUM_PLAYERS goals with multi-digit BCD scores. It runs the serve / rally / point / game-over sequence and declares a winner at a configurable score. It sits beside the ball and paddle blocks in the top level, consuming their hit/miss pulses and a per-frame tick, and driving ball enable plus the scores shown on the seven-segment controller.

## Interface
- NUM_PLAYERS, 2, number of goals/paddles (2..4)
- SCORE_DIGITS, 1, BCD digits per player score (1..4)
- WIN_SCORE, 9, binary winning score; 0 = endless match; must be ≤ 10^SCORE_DIGITS − 1
- SERVE_FRAMES, 60, frame ticks spent in SERVE before the ball is released
- HITS_PER_LEVEL, 4, rally hits per speed level (used only with PONG_SPEEDUP_EN)
- MAX_LEVEL, 3, speed level ceiling (used only with PONG_SPEEDUP_EN)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  debounced start key, level; rising edge detected internally
- frame_tick  in  1  one-cycle pulse per video frame
- hit  in  NUM_PLAYERS  one-cycle pulse: ball struck paddle i
- miss  in  NUM_PLAYERS  one-cycle pulse: ball passed goal i
- state  out  3  current state, encoding from pong_pkg
- ball_run  out  1  ball may move
- serve_to  out  PW  player receiving the next serve; PW = max(1, $clog2(NUM_PLAYERS))
- score  out  NUM_PLAYERS*4*SCORE_DIGITS  packed BCD scores; player 0 in the LSBs
- point_pulse  out  1  one cycle high in POINT
- winner  out  PW  winning player, valid in OVER
- winner_valid  out  1  high in OVER
- speed_level  out  $clog2(MAX_LEVEL+1)  ball speed level

## Operation
- States:
  - IDLE: start rise → SERVE.
  - SERVE: after SERVE_FRAMES ticks → PLAY.
  - PLAY: any miss → POINT.
  - POINT: → OVER if the credited score equals WIN_SCORE (WIN_SCORE ≠ 0), else → SERVE.
  - OVER: start rise → SERVE.
- Entering SERVE from IDLE or OVER: all scores cleared, serve_to = 0, last_hitter invalid.
- SERVE: ball_run = 0. The frame counter is cleared on entry and increments on each frame_tick. Exit occurs on the cycle the counter reaches SERVE_FRAMES. With SERVE_FRAMES = 0, SERVE lasts exactly one cycle.
- PLAY: ball_run = 1. hit[i] sets last_hitter = i and marks it valid.
- Miss handling in PLAY:
  - On a miss, i is the lowest set bit of miss.
  - The point is credited to last_hitter if it is valid and ≠ i. Otherwise no point is credited (own goal or no touch).
  - serve_to ← i.
  - If hit and miss are asserted in the same cycle, the miss wins and that hit is discarded.
- Score increment: BCD, digit 9 → 0 with carry. Saturates at all-nines; no wrap.
- start is ignored in SERVE, PLAY and POINT. hit/miss are ignored outside PLAY.
- OVER: ball_run = 0. winner = the player that reached WIN_SCORE. Scores hold until the next match starts.

## Timing
- Reset values: state = IDLE, ball_run = 0, serve_to = 0, score = 0, point_pulse = 0, winner = 0, winner_valid = 0, speed_level = 0, start edge register = 1 (a key held through reset does not start a game).
- Reset mid-operation: all outputs reach reset values on the cycle after reset is sampled.
- All outputs are registered.
- Miss sampled in cycle n: state = POINT, updated score and point_pulse all visible in n+1. The next state is visible in n+2.
- Start rise sampled in cycle n: state = SERVE in n+1.
- A frame_tick coinciding with the SERVE entry cycle is not counted.

## Configuration
- PONG_SPEEDUP_EN defined:
  - A rally-hit counter increments on each accepted hit in PLAY.
  - When the counter reaches HITS_PER_LEVEL, it clears and speed_level increments, saturating at MAX_LEVEL.
  - The counter and speed_level clear on SERVE entry.
- PONG_SPEEDUP_EN undefined: no counter logic; speed_level tied to 0.

## Structure
- pong_pkg:
  - state enum (IDLE, SERVE, PLAY, POINT, OVER)
  - the PW width function
  - bcd_inc saturating function
- One sub-module, pong_bcd_score: one player's SCORE_DIGITS-digit saturating BCD counter with clear, increment and a binary-equality compare against WIN_SCORE. Instantiated NUM_PLAYERS times via generate.

## Test plan
- Basic serve/point (defaults): start rise, 60 frame_ticks → PLAY. hit[1] then miss[0] → score = 0x10, serve_to = 0, point_pulse one cycle, back to SERVE.
- Own goal and simultaneity: miss[1] with no prior hit → no score change. In PLAY, hit[0] and miss[1] in the same cycle → no point, serve_to = 1.
- Win (WIN_SCORE = 3): three credited points to player 0 → OVER, winner = 0, winner_valid = 1. start rise → SERVE with score = 0.
- BCD/saturation (SCORE_DIGITS = 1, WIN_SCORE = 0, 11 points to player 1) → score[7:4] progresses 8, 9, 9. Four players, miss = 4'b0110 → miss[1] taken.
- Reset mid-PLAY with scores nonzero: reset one cycle → next cycle IDLE and all outputs 0. Holding start across reset does not start a game.
- PONG_SPEEDUP_EN: 13 hits in one rally → speed_level 3 (saturates). After a miss, SERVE → speed_level 0.
